// File: rtl/md_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op encodings and default latencies.
package md_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    function automatic logic is_md_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational signed/unsigned multiply and divide producing a {hi,lo} result.
module md_calc
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] cur_hi,
    input  logic [WIDTH-1:0] cur_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic               sgn, a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b, q_mag, r_mag, quot, rem;

    // Sign-extended operands give the signed product in the low 2*WIDTH bits.
    assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    // One magnitude divider serves both DIV and DIVU. Most-negative / -1 falls out
    // naturally: magnitude quotient 2**(WIDTH-1) wraps back to the most negative value.
    assign sgn   = (op == MD_DIV);
    assign a_neg = sgn & a[WIDTH-1];
    assign b_neg = sgn & b[WIDTH-1];
    assign mag_a = a_neg ? -a : a;
    assign mag_b = b_neg ? -b : b;
    assign q_mag = (mag_b == '0) ? '0 : mag_a / mag_b;
    assign r_mag = (mag_b == '0) ? '0 : mag_a % mag_b;
    assign quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign rem   = a_neg ? -r_mag : r_mag;

    always_comb begin
        res_hi = cur_hi;
        res_lo = cur_lo;
        case (op)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV, MD_DIVU: begin
                if (b != '0) begin
                    res_hi = rem;
                    res_lo = quot;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide sequencer with HI/LO registers for the EX stage.
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic             run, run_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [WIDTH-1:0] pend_hi, pend_lo, pend_hi_d, pend_lo_d;
    logic [WIDTH-1:0] hi_d, lo_d, calc_hi, calc_lo;
    logic             is_mult;

    md_calc #(.WIDTH(WIDTH)) u_calc (
        .op     (op),
        .a      (rs_data),
        .b      (rt_data),
        .cur_hi (hi),
        .cur_lo (lo),
        .res_hi (calc_hi),
        .res_lo (calc_lo)
    );

    assign is_mult = (op == MD_MULT) || (op == MD_MULTU);
    assign busy    = run;

    // While running, start/wr_en are ignored; the hazard unit keeps them low anyway.
    always_comb begin
        run_d     = run;
        cnt_d     = cnt;
        pend_hi_d = pend_hi;
        pend_lo_d = pend_lo;
        hi_d      = hi;
        lo_d      = lo;
        if (run) begin
            if (cnt == '0) begin
                run_d = 1'b0;
                hi_d  = pend_hi;
                lo_d  = pend_lo;
            end else begin
                cnt_d = cnt - CNT_W'(1);
            end
        end else if (start) begin
            if (is_md_op(op)) begin
                run_d     = 1'b1;
                cnt_d     = is_mult ? CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
                pend_hi_d = calc_hi;
                pend_lo_d = calc_lo;
            end
        end else if (wr_en) begin
            if (op == MD_MTHI)      hi_d = rs_data;
            else if (op == MD_MTLO) lo_d = rs_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run     <= 1'b0;
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            run     <= run_d;
            cnt     <= cnt_d;
            pend_hi <= pend_hi_d;
            pend_lo <= pend_lo_d;
            hi      <= hi_d;
            lo      <= lo_d;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: a cycle model built on 64-bit arithmetic plus literal checkpoints.
module tb_md_unit;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, wr_en;
    logic [2:0]  op;
    logic [31:0] rs_data, rt_data, hi, lo;
    logic        busy;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    md_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .wr_en(wr_en),
        .rs_data(rs_data), .rt_data(rt_data), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural result straight from the instruction semantics, in 64-bit math.
    function automatic logic [63:0] model_res(input logic [2:0] o, input logic [31:0] a, b,
                                              input logic [63:0] cur);
        longint sa, sb, q, r;
        longint unsigned ua, ub;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            MD_MULT:  return sa * sb;
            MD_MULTU: return ua * ub;
            MD_DIV: begin
                if (b == 0) return cur;
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            MD_DIVU: begin
                if (b == 0) return cur;
                return {32'(ua % ub), 32'(ua / ub)};
            end
            default: return cur;
        endcase
    endfunction

    // Model: remaining busy cycles and the result that lands when they run out.
    int          m_left = 0;
    logic [63:0] m_hilo = '0, m_pend = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_left = 0;
            m_hilo = '0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_hilo = m_pend;
        end else if (start) begin
            if (op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU}) begin
                m_pend = model_res(op, rs_data, rt_data, m_hilo);
                m_left = (op inside {MD_MULT, MD_MULTU}) ? MD_MULT_CYCLES : MD_DIV_CYCLES;
            end
        end else if (wr_en) begin
            if (op == MD_MTHI)      m_hilo[63:32] = rs_data;
            else if (op == MD_MTLO) m_hilo[31:0]  = rs_data;
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("cyc_busy", 32'(busy), 32'(m_left > 0));
            chk("cyc_hi", hi, m_hilo[63:32]);
            chk("cyc_lo", lo, m_hilo[31:0]);
        end
    end

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, b, output int bcyc);
        @(negedge clk);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        @(negedge clk);
        start = 1'b0; op = MD_NONE;
        bcyc = 0;
        while (busy && bcyc < 100) begin
            bcyc++;
            @(negedge clk);
        end
    endtask

    int n;

    initial begin
        reset = 1'b1; start = 1'b0; wr_en = 1'b0; op = MD_NONE;
        rs_data = '0; rt_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        reset = 1'b0;
        chk_en = 1'b1;

        run_op(MD_MULT, -32'sd3, 32'd7, n);
        chk("mult_lat", n, 5);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFEB);

        run_op(MD_MULTU, 32'hFFFFFFFF, 32'd2, n);
        chk("multu_lat", n, 5);
        chk("multu_hi", hi, 32'h1);
        chk("multu_lo", lo, 32'hFFFFFFFE);

        run_op(MD_DIV, -32'sd7, 32'd2, n);
        chk("div_lat", n, 10);
        chk("div_hi", hi, 32'hFFFFFFFF);
        chk("div_lo", lo, 32'hFFFFFFFD);

        run_op(MD_DIVU, 32'd7, 32'd0, n);
        chk("divu0_lat", n, 10);
        chk("divu0_hi", hi, 32'hFFFFFFFF);
        chk("divu0_lo", lo, 32'hFFFFFFFD);

        run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, n);
        chk("ovf_hi", hi, 32'h0);
        chk("ovf_lo", lo, 32'h80000000);

        run_op(MD_DIV, 32'd7, -32'sd2, n);
        chk("div_neg_hi", hi, 32'd1);
        chk("div_neg_lo", lo, 32'hFFFFFFFD);

        run_op(MD_DIVU, 32'hFFFFFFF0, 32'd16, n);
        chk("divu_hi", hi, 32'd0);
        chk("divu_lo", lo, 32'h0FFFFFFF);

        // MTHI then MTLO back to back
        @(negedge clk);
        wr_en = 1'b1; op = MD_MTHI; rs_data = 32'h1234;
        @(negedge clk);
        op = MD_MTLO; rs_data = 32'h5678;
        @(negedge clk);
        wr_en = 1'b0; op = MD_NONE;
        chk("mt_busy", 32'(busy), 32'd0);
        chk("mt_hi", hi, 32'h1234);
        chk("mt_lo", lo, 32'h5678);

        // start with an mt op and wr_en with an md op are both ignored
        @(negedge clk);
        start = 1'b1; op = MD_MTHI; rs_data = 32'hABCD;
        @(negedge clk);
        start = 1'b0; wr_en = 1'b1; op = MD_MULT; rs_data = 32'h9999; rt_data = 32'd3;
        @(negedge clk);
        wr_en = 1'b0; op = MD_NONE;
        chk("ign_busy", 32'(busy), 32'd0);
        chk("ign_hi", hi, 32'h1234);
        chk("ign_lo", lo, 32'h5678);

        // reset in the third busy cycle of a DIV
        @(negedge clk);
        start = 1'b1; op = MD_DIV; rs_data = 32'd100; rt_data = 32'd7;
        @(negedge clk);
        start = 1'b0; op = MD_NONE;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        run_op(MD_MULT, 32'd6, 32'd7, n);
        chk("post_rst_lat", n, 5);
        chk("post_rst_lo", lo, 32'd42);
        chk("post_rst_hi", hi, 32'd0);

        // second start mid-run must not disturb the first operation
        @(negedge clk);
        start = 1'b1; op = MD_MULT; rs_data = 32'd5; rt_data = 32'd5;
        @(negedge clk);
        start = 1'b0; op = MD_NONE;
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (n == 2) begin
                start = 1'b1; op = MD_DIV; rs_data = 32'd100; rt_data = 32'd3;
            end else begin
                start = 1'b0; op = MD_NONE;
            end
            @(negedge clk);
        end
        start = 1'b0; op = MD_NONE;
        chk("restart_lat", n, 5);
        chk("restart_lo", lo, 32'd25);
        chk("restart_hi", hi, 32'd0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
